// File: rtl/trap_detector_pkg.sv
// Shared trap definitions: trap codes seen by the trap controller plus the
// instruction encodings the trap decoder matches against.
package trap_detector_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned TRAP_CODE_W = 3;

    typedef enum logic [TRAP_CODE_W-1:0] {
        TRAP_NONE       = 3'd0,
        TRAP_EBREAK     = 3'd1,
        TRAP_ECALL      = 3'd2,
        TRAP_MISALIGNED = 3'd3,
        TRAP_FENCEI     = 3'd4,
        TRAP_MRET       = 3'd5
    } trap_code_e;

    localparam logic [XLEN-1:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [XLEN-1:0] INSTR_MRET   = 32'h3020_0073;
    localparam logic [6:0]      OPC_MISC_MEM = 7'h0F;
    localparam logic [2:0]      F3_FENCEI    = 3'b001;

    // FENCEI and MRET are held for a fixed time instead of waiting on the controller.
    function automatic logic is_single_cycle(input logic [TRAP_CODE_W-1:0] code);
        return (code == TRAP_FENCEI) || (code == TRAP_MRET);
    endfunction

endpackage

// File: rtl/trap_decoder.sv
// Combinational trap decode of the committing instruction and redirect target.
// TRAP_MISALIGN_CHECK_EN enables the misaligned-target trap.
module trap_decoder
    import trap_detector_pkg::*;
(
    input  logic                   instr_valid,
    input  logic [XLEN-1:0]        instruction,
    input  logic                   branch_taken,
    input  logic [XLEN-1:0]        branch_target,
    output logic                   trap_detect,
    output logic [TRAP_CODE_W-1:0] trap_code
);

    logic       misaligned;
    logic       is_fencei;
    trap_code_e code;

`ifdef TRAP_MISALIGN_CHECK_EN
    logic unused_target_hi;
    assign misaligned       = branch_taken && (branch_target[1:0] != 2'b00);
    assign unused_target_hi = ^branch_target[XLEN-1:2];
`else
    logic unused_branch;
    assign misaligned    = 1'b0;
    assign unused_branch = ^{branch_taken, branch_target};
`endif

    assign is_fencei = (instruction[6:0] == OPC_MISC_MEM) && (instruction[14:12] == F3_FENCEI);

    // Misaligned redirect outranks the decode-based traps.
    always_comb begin
        code = TRAP_NONE;
        if (instr_valid) begin
            if (misaligned)                         code = TRAP_MISALIGNED;
            else if (instruction == INSTR_ECALL)    code = TRAP_ECALL;
            else if (instruction == INSTR_EBREAK)   code = TRAP_EBREAK;
            else if (instruction == INSTR_MRET)     code = TRAP_MRET;
            else if (is_fencei)                     code = TRAP_FENCEI;
        end
    end

    assign trap_code   = code;
    assign trap_detect = (code != TRAP_NONE);

endmodule

// File: rtl/trap_detector.sv
// Trap issue stage: captures trap code and PC, holds them through the
// controller handshake and stalls the pipeline. TRAP_MISALIGN_CHECK_EN: see trap_decoder.
module trap_detector
    import trap_detector_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    input  logic [XLEN-1:0]        instruction,
    input  logic [XLEN-1:0]        pc,
    input  logic                   branch_taken,
    input  logic [XLEN-1:0]        branch_target,
    input  logic                   trap_done,
    output logic [TRAP_CODE_W-1:0] trap_status,
    output logic [XLEN-1:0]        trap_pc,
    output logic                   pc_stall,
    output logic                   trap_busy,
    output logic                   timeout_error
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_ACK  = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_HOLD      = 3'd3,
        S_RELEASE   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [TRAP_CODE_W-1:0] status_q, status_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   err_q, err_d;
    logic                   busy_q;
    logic                   dec_detect;
    logic [TRAP_CODE_W-1:0] dec_code;

    trap_decoder u_decoder (
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .trap_detect   (dec_detect),
        .trap_code     (dec_code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            status_q <= TRAP_NONE;
            pc_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

    // Next-state: new traps are only accepted in IDLE; every exit passes through RELEASE.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        cnt_inc  = cnt_q + CNT_W'(1);
        unique case (state_q)
            S_IDLE: begin
                if (dec_detect) begin
                    status_d = dec_code;
                    pc_d     = pc;
                    cnt_d    = '0;
                    state_d  = is_single_cycle(dec_code) ? S_HOLD : S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                cnt_d = cnt_inc;
                // A fall arriving on the timeout edge still counts as an acknowledge.
                if (!trap_done) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
                    err_d    = 1'b1;
                    status_d = TRAP_NONE;
                    state_d  = S_RELEASE;
                end
            end
            S_WAIT_DONE: begin
                if (trap_done) begin
                    status_d = TRAP_NONE;
                    state_d  = S_RELEASE;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(HOLD_CYCLES)) begin
                    status_d = TRAP_NONE;
                    state_d  = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign pc_stall      = (state_q == S_IDLE) ? dec_detect : 1'b1;
    assign trap_status   = status_q;
    assign trap_pc       = pc_q;
    assign trap_busy     = busy_q;
    assign timeout_error = err_q;

endmodule

// File: tb/tb_trap_detector.sv
// Self-checking bench for trap_detector: decode table, directed handshake
// sequences and randomized traffic against a behavioural reference model.
module tb_trap_detector;

    localparam int unsigned HOLD = 2;
    localparam int unsigned ACK  = 15;
`ifdef TRAP_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    localparam logic [31:0] I_ECALL  = 32'h0000_0073;
    localparam logic [31:0] I_EBREAK = 32'h0010_0073;
    localparam logic [31:0] I_MRET   = 32'h3020_0073;
    localparam logic [31:0] I_JAL    = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap_done;
    logic [2:0]  trap_status;
    logic [31:0] trap_pc;
    logic        pc_stall;
    logic        trap_busy;
    logic        timeout_error;

    trap_detector #(.HOLD_CYCLES(HOLD), .ACK_TIMEOUT(ACK)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .trap_done     (trap_done),
        .trap_status   (trap_status),
        .trap_pc       (trap_pc),
        .pc_stall      (pc_stall),
        .trap_busy     (trap_busy),
        .timeout_error (timeout_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: a trap in flight is described by its kind and age in cycles.
    bit          m_busy;
    bit          m_rel;
    bit          m_hold;
    bit          m_fell;
    bit          m_err;
    int unsigned m_age;
    logic [2:0]  m_status;
    logic [31:0] m_pc;

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        bt;
        logic [31:0] tgt;
        logic [2:0]  exp;
    } vec_t;

    function automatic int ref_decode(logic v, logic [31:0] ins, logic bt, logic [31:0] tgt);
        if (!v) return 0;
        if (MIS_EN && bt && (tgt[1:0] != 2'b00)) return 3;
        if (ins == I_ECALL)  return 2;
        if (ins == I_EBREAK) return 1;
        if (ins == I_MRET)   return 5;
        if (ins[6:0] == 7'h0F && ins[14:12] == 3'b001) return 4;
        return 0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(int code);
        bit fin;
        fin = 1'b0;
        if (reset) begin
            m_busy = 0; m_rel = 0; m_err = 0; m_status = 3'd0; m_pc = '0;
        end else if (m_rel) begin
            m_rel = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (code != 0) begin
                m_status = 3'(code); m_pc = pc; m_busy = 1; m_age = 0; m_fell = 0;
                m_hold = (code == 4) || (code == 5);
            end
        end else begin
            m_age++;
            if (m_hold) begin
                fin = (m_age >= HOLD);
            end else if (!m_fell) begin
                if (!trap_done) m_fell = 1;
                else if (m_age >= ACK) begin m_err = 1; fin = 1; end
            end else begin
                fin = trap_done;
            end
            if (fin) begin m_status = 3'd0; m_rel = 1; end
        end
    endtask

    // One clock: check the combinational stall, advance, check registered outputs.
    task automatic tick();
        int code;
        #1;
        code = ref_decode(instr_valid, instruction, branch_taken, branch_target);
        chk("pc_stall", 32'(pc_stall), (m_busy || code != 0) ? 32'd1 : 32'd0);
        @(posedge clk);
        model_step(code);
        cyc++;
        #1;
        chk("trap_status", 32'(trap_status), 32'(m_status));
        chk("trap_pc", trap_pc, m_pc);
        chk("trap_busy", 32'(trap_busy), 32'(m_busy));
        chk("timeout_error", 32'(timeout_error), 32'(m_err));
    endtask

    task automatic set_in(logic v, logic [31:0] ins, logic [31:0] p, logic bt, logic [31:0] tgt);
        instr_valid = v; instruction = ins; pc = p; branch_taken = bt; branch_target = tgt;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        trap_done = 1'b0;
        tick();
        trap_done = 1'b1;
        for (int i = 0; i < 40 && m_busy; i++) tick();
        chk("drain_busy", 32'(trap_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        int          n_fence;
        int          n_rel;
        int          done_mode;
        logic [31:0] r;
        logic [31:0] ins;

        reset = 1'b1;
        trap_done = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        m_status = 3'd0; m_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_status", 32'(trap_status), 32'd0);
        chk("reset_pc", trap_pc, 32'd0);
        chk("reset_busy", 32'(trap_busy), 32'd0);
        chk("reset_err", 32'(timeout_error), 32'd0);
        chk("reset_stall", 32'(pc_stall), 32'd0);
        reset = 1'b0;

        // Decode table, each entry applied from IDLE.
        vecs.push_back('{1'b1, I_ECALL,       1'b0, 32'h0,   3'd2});
        vecs.push_back('{1'b1, I_EBREAK,      1'b0, 32'h0,   3'd1});
        vecs.push_back('{1'b1, I_MRET,        1'b0, 32'h0,   3'd5});
        vecs.push_back('{1'b1, 32'h0000_100F, 1'b0, 32'h0,   3'd4});
        vecs.push_back('{1'b1, 32'hFFFF_908F, 1'b0, 32'h0,   3'd4});
        vecs.push_back('{1'b1, 32'h0000_000F, 1'b0, 32'h0,   3'd0});
        vecs.push_back('{1'b0, I_ECALL,       1'b0, 32'h0,   3'd0});
        vecs.push_back('{1'b1, 32'h0020_0073, 1'b0, 32'h0,   3'd0});
        vecs.push_back('{1'b1, 32'h0000_0013, 1'b1, 32'h202, MIS_EN ? 3'd3 : 3'd0});
        vecs.push_back('{1'b1, I_ECALL,       1'b1, 32'h204, 3'd2});
        vecs.push_back('{1'b1, I_ECALL,       1'b1, 32'h201, MIS_EN ? 3'd3 : 3'd2});
        vecs.push_back('{1'b0, 32'h0000_0013, 1'b1, 32'h203, 3'd0});
        foreach (vecs[i]) begin
            reset_dut();
            set_in(vecs[i].v, vecs[i].ins, 32'h1000 + 32'(i * 4), vecs[i].bt, vecs[i].tgt);
            #1 chk("table_stall", 32'(pc_stall), (vecs[i].exp != 3'd0) ? 32'd1 : 32'd0);
            tick();
            chk("table_status", 32'(trap_status), 32'(vecs[i].exp));
        end

        // ECALL with a nominal controller handshake.
        reset_dut();
        set_in(1'b1, I_ECALL, 32'h100, 1'b0, 32'h0);
        tick();
        chk("ecall_status", 32'(trap_status), 32'd2);
        chk("ecall_pc", trap_pc, 32'h100);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        trap_done = 1'b0;
        repeat (3) tick();
        chk("ecall_held", 32'(trap_status), 32'd2);
        trap_done = 1'b1;
        tick();
        chk("ecall_none", 32'(trap_status), 32'd0);
        chk("ecall_release", 32'(trap_busy), 32'd1);
        tick();
        chk("ecall_idle", 32'(trap_busy), 32'd0);

        // FENCE.I hold length and single RELEASE cycle.
        reset_dut();
        set_in(1'b1, 32'hFFFF_908F, 32'h200, 1'b0, 32'h0);
        tick();
        n_fence = (trap_status == 3'd4) ? 1 : 0;
        n_rel = 0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (5) begin
            tick();
            if (trap_status == 3'd4) n_fence++;
            if (trap_busy && trap_status == 3'd0) n_rel++;
        end
        chk("fencei_len", 32'(n_fence), 32'(HOLD));
        chk("fencei_release", 32'(n_rel), 32'd1);
        chk("fencei_err", 32'(timeout_error), 32'd0);

        // Taken JAL to a misaligned target.
        reset_dut();
        set_in(1'b1, I_JAL, 32'h300, 1'b1, 32'h202);
        #1 chk("jal_stall", 32'(pc_stall), 32'(MIS_EN));
        tick();
        chk("jal_status", 32'(trap_status), MIS_EN ? 32'd3 : 32'd0);
        drain();

        // EBREAK with trap_done stuck high.
        reset_dut();
        set_in(1'b1, I_EBREAK, 32'h400, 1'b0, 32'h0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (ACK - 1) tick();
        chk("to_err_early", 32'(timeout_error), 32'd0);
        chk("to_status_early", 32'(trap_status), 32'd1);
        tick();
        chk("to_err", 32'(timeout_error), 32'd1);
        chk("to_status", 32'(trap_status), 32'd0);
        tick();
        chk("to_idle", 32'(trap_busy), 32'd0);
        repeat (3) tick();
        chk("to_sticky", 32'(timeout_error), 32'd1);

        // trap_done falls on the timeout edge: acknowledge wins.
        reset_dut();
        set_in(1'b1, I_ECALL, 32'h440, 1'b0, 32'h0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (ACK - 1) tick();
        trap_done = 1'b0;
        tick();
        chk("race_err", 32'(timeout_error), 32'd0);
        chk("race_status", 32'(trap_status), 32'd2);
        trap_done = 1'b1;
        tick();
        chk("race_none", 32'(trap_status), 32'd0);
        drain();

        // Reset while in WAIT_DONE.
        reset_dut();
        set_in(1'b1, I_ECALL, 32'h500, 1'b0, 32'h0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        trap_done = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        trap_done = 1'b1;
        chk("rst_status", 32'(trap_status), 32'd0);
        chk("rst_busy", 32'(trap_busy), 32'd0);
        chk("rst_pc", trap_pc, 32'd0);

        // MRET ignored while busy and in RELEASE, accepted in IDLE.
        set_in(1'b1, I_ECALL, 32'h580, 1'b0, 32'h0);
        tick();
        set_in(1'b1, I_MRET, 32'h600, 1'b0, 32'h0);
        trap_done = 1'b0;
        repeat (2) tick();
        chk("mret_ignored", 32'(trap_status), 32'd2);
        chk("mret_pc_kept", trap_pc, 32'h580);
        trap_done = 1'b1;
        tick();
        tick();
        chk("mret_release_ignored", 32'(trap_status), 32'd0);
        tick();
        chk("mret_idle", 32'(trap_status), 32'd5);
        chk("mret_pc", trap_pc, 32'h600);
        drain();

        // Randomized traffic against the model.
        done_mode = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 64 == 0) done_mode = int'($urandom_range(0, 2));
            r = $urandom();
            case ($urandom_range(0, 7))
                0:       ins = I_ECALL;
                1:       ins = I_EBREAK;
                2:       ins = I_MRET;
                3:       ins = {r[31:15], 3'b001, r[11:7], 7'h0F};
                4:       ins = I_JAL;
                default: ins = $urandom();
            endcase
            set_in(1'($urandom_range(0, 1)), ins, $urandom(), $urandom_range(0, 3) == 0, $urandom());
            trap_done = (done_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
